// File: rtl/mult_pkg.sv
// Purpose: shared FSM state encoding and counter sizing for the shift-and-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

  // Raw 2-bit state codes, also used as the enum values below.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE
  } state_e;

  // Iteration counter width: $clog2(WIDTH), never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_add_mult_core_if.sv
// Purpose: request/response bundle for the multiplier (operands + start in, status + product out).
// Latency: n/a (wires only).
// Backpressure: none; i_start is ignored while o_busy is high.
// Ports: i_start, i_signed, i_a, i_b (master -> slave); o_busy, o_done, o_product (slave -> master).
interface shift_add_mult_core_if #(
  parameter int WIDTH = 8
);
  logic               i_start;
  logic               i_signed;
  logic [WIDTH-1:0]   i_a;
  logic [WIDTH-1:0]   i_b;
  logic               o_busy;
  logic               o_done;
  logic [2*WIDTH-1:0] o_product;

  modport master (
    output i_start, i_signed, i_a, i_b,
    input  o_busy, o_done, o_product
  );

  modport slave (
    input  i_start, i_signed, i_a, i_b,
    output o_busy, o_done, o_product
  );
endinterface

// File: rtl/mult_addshift_dp.sv
// Purpose: multiplier datapath - B register, WIDTH+1-bit adder, {acc,A} shift register, remaining-bit zero detect.
// Latency: one iteration per clock when i_shift; aligned product is combinational from the registers.
// Backpressure: none; fully controlled by the owning FSM.
// Ports: i_clk, i_clear (sync clear), i_load + i_a_mag/i_b_mag, i_shift, i_iter (current iteration),
//        i_align_cnt (extra right shifts), o_rem_zero, o_prod_aligned.
module mult_addshift_dp import mult_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic               i_clk,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_a_mag,
  input  logic [WIDTH-1:0]   i_b_mag,
  input  logic               i_shift,
  input  logic [CNT_W-1:0]   i_iter,
  input  logic [CNT_W-1:0]   i_align_cnt,
  output logic               o_rem_zero,
  output logic [2*WIDTH-1:0] o_prod_aligned
);

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] rem_mask;

  // Carry kept in sum[WIDTH]; it becomes the new acc MSB after the shift.
  assign sum = {1'b0, acc_q} + {1'b0, (a_q[0] ? b_q : {WIDTH{1'b0}})};

  // At iteration k, A[WIDTH-1-k:1] still holds unprocessed multiplier bits;
  // everything above that is already product.
  assign rem_mask   = {WIDTH{1'b1}} >> (32'(i_iter) + 32'd1);
  assign o_rem_zero = ((a_q >> 1) & rem_mask) == {WIDTH{1'b0}};

  // Early exit skips zero-bit iterations, which are pure right shifts.
  assign o_prod_aligned = {acc_q, a_q} >> i_align_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      b_q   <= '0;
      acc_q <= '0;
      a_q   <= '0;
    end else if (i_load) begin
      b_q   <= i_b_mag;
      acc_q <= '0;
      a_q   <= i_a_mag;
    end else if (i_shift) begin
      {acc_q, a_q} <= {sum, a_q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_add_mult_core.sv
// Purpose: sequential shift-and-add multiplier; FSM, iteration counter and sign handling around the datapath.
// Latency: o_done in cycle N+2 after the accept cycle (N = WIDTH, or fewer with EARLY_EXIT).
// Backpressure: i_start accepted only in IDLE/DONE; ignored while o_busy.
// Ports: i_clk, i_rst (sync, active-high), bus (slave: i_start/i_signed/i_a/i_b in, o_busy/o_done/o_product out).
module shift_add_mult_core import mult_pkg::*; #(
  parameter int WIDTH      = 8,
  parameter int SIGNED_EN  = 1,
  parameter int EARLY_EXIT = 0
) (
  input logic                  i_clk,
  input logic                  i_rst,
  shift_add_mult_core_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic                 sgn;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 dp_load, dp_shift, rem_zero, last_iter;
  logic [2*WIDTH-1:0]   prod_aligned;

  // With SIGNED_EN=0 this folds to 0 and the magnitude muxes disappear.
  assign sgn   = bus.i_signed & (SIGNED_EN != 0);
  assign a_mag = (sgn & bus.i_a[WIDTH-1]) ? (~bus.i_a + WIDTH'(1)) : bus.i_a;
  assign b_mag = (sgn & bus.i_b[WIDTH-1]) ? (~bus.i_b + WIDTH'(1)) : bus.i_b;

  assign last_iter = (cnt_q == LAST_CNT) || ((EARLY_EXIT != 0) && rem_zero);

  mult_addshift_dp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dp (
    .i_clk          (i_clk),
    .i_clear        (i_rst),
    .i_load         (dp_load),
    .i_a_mag        (a_mag),
    .i_b_mag        (b_mag),
    .i_shift        (dp_shift),
    .i_iter         (cnt_q),
    .i_align_cnt    (LAST_CNT - cnt_q),
    .o_rem_zero     (rem_zero),
    .o_prod_aligned (prod_aligned)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    dp_load  = 1'b0;
    dp_shift = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.i_start) begin
          dp_load = 1'b1;
          cnt_d   = '0;
          neg_d   = sgn & (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
          state_d = S_CALC;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        dp_shift = 1'b1;
        // cnt is frozen on the last iteration so FIX can derive the realign distance.
        if (last_iter) state_d = S_FIX;
        else           cnt_d   = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        prod_d  = neg_q ? (~prod_aligned + (2*WIDTH)'(1)) : prod_aligned;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.o_busy    = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.o_done    = (state_q == S_DONE);
  assign bus.o_product = prod_q;

endmodule

// File: tb/tb_shift_add_mult_core.sv
// Purpose: self-checking bench for shift_add_mult_core (WIDTH=8), one instance without and one with early exit.
// Latency: checks o_done cycle index against the N+2 rule for both instances.
// Backpressure: exercises ignored mid-operation starts and back-to-back starts in DONE.
module tb_shift_add_mult_core;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_add_mult_core_if #(.WIDTH(W)) bus0 ();
  shift_add_mult_core_if #(.WIDTH(W)) bus1 ();

  shift_add_mult_core #(.WIDTH(W), .SIGNED_EN(1), .EARLY_EXIT(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0)
  );
  shift_add_mult_core #(.WIDTH(W), .SIGNED_EN(1), .EARLY_EXIT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer product of the operands as interpreted.
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic s);
    int pa, pb;
    pa = s ? int'($signed(a)) : int'(a);
    pb = s ? int'($signed(b)) : int'(b);
    return 16'(pa * pb);
  endfunction

  // Reference early-exit latency: N = max(1, highest set bit of |a| + 1), done at N+2.
  function automatic int ref_lat_ee(input logic [7:0] a, input logic s);
    int mag, n;
    mag = (s && a[7]) ? (256 - int'(a)) : int'(a);
    n = 1;
    for (int i = 0; i < 9; i++) if (((mag >> i) & 1) == 1) n = i + 1;
    return n + 2;
  endfunction

  // Output monitor: o_done never wider than one cycle; o_product moves only when o_done appears or after reset.
  logic        mon_en = 1'b0;
  logic        mon_rst;
  logic        pdone0, pdone1;
  logic [15:0] pprod0, pprod1;

  always @(posedge clk) begin
    mon_rst = rst;
    #1;
    if (mon_en) begin
      if (bus0.o_done) chk("done_width0", 32'(pdone0), 32'd0);
      if (bus1.o_done) chk("done_width1", 32'(pdone1), 32'd0);
      if (!bus0.o_done && !mon_rst) chk("prod_stable0", 32'(bus0.o_product), 32'(pprod0));
      if (!bus1.o_done && !mon_rst) chk("prod_stable1", 32'(bus1.o_product), 32'(pprod1));
    end
    pdone0 = bus0.o_done;
    pdone1 = bus1.o_done;
    pprod0 = bus0.o_product;
    pprod1 = bus1.o_product;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start both instances together; returns each product and the cycle index of its o_done
  // (accept cycle = 0). Returns -1 latency on timeout, which fails the caller's compare.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] p0, output logic [15:0] p1,
                        output int l0, output int l1);
    bit g0, g1;
    int cyc;
    bus0.i_a = a; bus0.i_b = b; bus0.i_signed = s; bus0.i_start = 1'b1;
    bus1.i_a = a; bus1.i_b = b; bus1.i_signed = s; bus1.i_start = 1'b1;
    step();
    bus0.i_start = 1'b0; bus1.i_start = 1'b0;
    bus0.i_a = 8'($urandom); bus0.i_b = 8'($urandom); bus0.i_signed = 1'($urandom);
    bus1.i_a = 8'($urandom); bus1.i_b = 8'($urandom); bus1.i_signed = 1'($urandom);
    g0 = 0; g1 = 0; l0 = -1; l1 = -1; p0 = '0; p1 = '0; cyc = 1;
    while (!(g0 && g1) && cyc <= 30) begin
      if (!g0 && bus0.o_done) begin g0 = 1; l0 = cyc; p0 = bus0.o_product; end
      if (!g1 && bus1.o_done) begin g1 = 1; l1 = cyc; p1 = bus1.o_product; end
      if (!(g0 && g1)) begin step(); cyc++; end
    end
  endtask

  // dut0 only: advance until o_done, bounded.
  task automatic wait_done0(inout int cyc, output logic [15:0] p);
    while (!bus0.o_done && cyc <= 30) begin step(); cyc++; end
    p = bus0.o_product;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] prod;
    int          lat_ee;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [15:0] p0, p1, pr;
    int l0, l1, cyc, dones;
    logic [7:0] ra, rb;

    tbl[0] = '{8'd13,  8'd11,  1'b0, 16'h008F, 6};
    tbl[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01, 10};
    tbl[2] = '{8'hFD,  8'h05,  1'b1, 16'hFFF1, 4};
    tbl[3] = '{8'h80,  8'h80,  1'b1, 16'h4000, 10};
    tbl[4] = '{8'h80,  8'h01,  1'b1, 16'hFF80, 10};
    tbl[5] = '{8'h00,  8'hF9,  1'b1, 16'h0000, 3};
    tbl[6] = '{8'h03,  8'h07,  1'b0, 16'h0015, 4};
    tbl[7] = '{8'h00,  8'h55,  1'b0, 16'h0000, 3};
    tbl[8] = '{8'h80,  8'h02,  1'b0, 16'h0100, 10};
    tbl[9] = '{8'hFF,  8'hFF,  1'b1, 16'h0001, 3};

    rst = 1'b1;
    bus0.i_start = 1'b0; bus0.i_signed = 1'b0; bus0.i_a = '0; bus0.i_b = '0;
    bus1.i_start = 1'b0; bus1.i_signed = 1'b0; bus1.i_a = '0; bus1.i_b = '0;
    repeat (3) step();
    chk("rst_busy0", 32'(bus0.o_busy), 32'd0);
    chk("rst_done0", 32'(bus0.o_done), 32'd0);
    chk("rst_prod0", 32'(bus0.o_product), 32'd0);
    chk("rst_busy1", 32'(bus1.o_busy), 32'd0);
    chk("rst_prod1", 32'(bus1.o_product), 32'd0);
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Directed vectors on both instances.
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, p0, p1, l0, l1);
      chk($sformatf("vec%0d_prod0", i), 32'(p0), 32'(tbl[i].prod));
      chk($sformatf("vec%0d_prod1", i), 32'(p1), 32'(tbl[i].prod));
      chk($sformatf("vec%0d_lat0", i), l0, 10);
      chk($sformatf("vec%0d_lat1", i), l1, tbl[i].lat_ee);
    end
    step();

    // Start pulsed mid-CALC on dut0 must be ignored.
    bus0.i_a = 8'd13; bus0.i_b = 8'd11; bus0.i_signed = 1'b0; bus0.i_start = 1'b1;
    step(); cyc = 1;
    bus0.i_start = 1'b0;
    step(); step(); cyc = 3;
    bus0.i_a = 8'd200; bus0.i_b = 8'd200; bus0.i_start = 1'b1;
    step(); cyc++;
    bus0.i_start = 1'b0;
    wait_done0(cyc, pr);
    chk("midcalc_prod", 32'(pr), 32'h008F);
    chk("midcalc_lat", cyc, 10);

    // Start held in the DONE cycle: accepted, busy on the next cycle.
    bus0.i_a = 8'd5; bus0.i_b = 8'd6; bus0.i_start = 1'b1;
    step(); cyc = 1;
    bus0.i_start = 1'b0;
    chk("b2b_busy", 32'(bus0.o_busy), 32'd1);
    wait_done0(cyc, pr);
    chk("b2b_prod", 32'(pr), 32'd30);
    chk("b2b_lat", cyc, 10);
    step();

    // Reset in CALC cycle 4 aborts the operation.
    bus0.i_a = 8'd13; bus0.i_b = 8'd11; bus0.i_start = 1'b1;
    step();
    bus0.i_start = 1'b0;
    step(); step(); step();
    chk("pre_rst_busy", 32'(bus0.o_busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(bus0.o_busy), 32'd0);
    chk("abort_prod", 32'(bus0.o_product), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus0.o_done) dones++;
      step();
    end
    chk("abort_no_done", dones, 0);

    // Random operands, unsigned then signed; a is sometimes narrowed to exercise early exit.
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 2000; i++) begin
        ra = 8'($urandom) >> $urandom_range(0, 7);
        rb = 8'($urandom);
        run_op(ra, rb, 1'(mode), p0, p1, l0, l1);
        chk($sformatf("rnd_prod0 a=%0h b=%0h s=%0d", ra, rb, mode), 32'(p0), 32'(ref_prod(ra, rb, 1'(mode))));
        chk($sformatf("rnd_prod1 a=%0h b=%0h s=%0d", ra, rb, mode), 32'(p1), 32'(ref_prod(ra, rb, 1'(mode))));
        chk($sformatf("rnd_lat0 a=%0h s=%0d", ra, mode), l0, 10);
        chk($sformatf("rnd_lat1 a=%0h s=%0d", ra, mode), l1, ref_lat_ee(ra, 1'(mode)));
      end
    end

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
